// File: rtl/mic1_mem_arbiter.sv
// mic1_mem_arbiter: shares one memory port between the MIC-1 byte fetch port and word data port,
// alternating grants under contention and aborting with err when the memory never answers.
module mic1_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [7:0]        f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-3:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              err,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-3:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;
  state_t            state, state_n;
  logic              last_d, last_n, grant_f, expire;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        lane, lane_n;
  logic              mv_n, we_n, fa_n, da_n, err_n;
  logic [ADDR_W-3:0] addr_n;
  logic [31:0]       wd_n, dr_n;
  logic [7:0]        fr_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      cnt     <= '0;
      lane    <= '0;
      m_valid <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state   <= state_n;
      last_d  <= last_n;
      cnt     <= cnt_n;
      lane    <= lane_n;
      m_valid <= mv_n;
      m_we    <= we_n;
      m_addr  <= addr_n;
      m_wdata <= wd_n;
      f_ack   <= fa_n;
      d_ack   <= da_n;
      err     <= err_n;
      f_rdata <= fr_n;
      d_rdata <= dr_n;
    end
  end
  // Under contention the port not served last time wins; lone requests win outright.
  always_comb begin
    state_n = state;
    last_n  = last_d;
    cnt_n   = cnt;
    lane_n  = lane;
    mv_n    = m_valid;
    we_n    = m_we;
    addr_n  = m_addr;
    wd_n    = m_wdata;
    fa_n    = 1'b0;
    da_n    = 1'b0;
    err_n   = 1'b0;
    fr_n    = f_rdata;
    dr_n    = d_rdata;
    grant_f = f_req && (!d_req || last_d);
    expire  = cnt >= CW'(TIMEOUT - 1);
    if (state == IDLE) begin
      if (f_req || d_req) begin
        state_n = grant_f ? BUSY_F : BUSY_D;
        last_n  = !grant_f;
        cnt_n   = '0;
        lane_n  = f_addr[1:0];
        mv_n    = 1'b1;
        we_n    = !grant_f && d_we;
        addr_n  = grant_f ? f_addr[ADDR_W-1:2] : d_addr;
        wd_n    = grant_f ? '0 : d_wdata;
      end
    end else if (m_ready || expire) begin
      state_n = IDLE;
      mv_n    = 1'b0;
      fa_n    = state == BUSY_F;
      da_n    = state == BUSY_D;
      err_n   = !m_ready;
      fr_n    = (m_ready && state == BUSY_F) ? m_rdata[8*(3-int'(lane)) +: 8] : f_rdata;
      dr_n    = (m_ready && state == BUSY_D && !m_we) ? m_rdata : d_rdata;
    end else begin
      cnt_n = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
    end
  end
endmodule
